// File: rtl/touch_event_gen_if.sv
// touch_event_gen_if: raw touch samples in, debounced touch_data out.
// master = panel front end / consumer side, slave = touch_event_gen.
interface touch_event_gen_if;
   logic        raw_valid;
   logic        raw_pressed;
   logic [15:0] raw_x;
   logic [15:0] raw_y;
   logic [31:0] touch_data;
   logic        touch_event;
   logic        busy;
   logic [7:0]  event_count;

   modport master (
      output raw_valid, raw_pressed, raw_x, raw_y,
      input  touch_data, touch_event, busy, event_count
   );

   modport slave (
      input  raw_valid, raw_pressed, raw_x, raw_y,
      output touch_data, touch_event, busy, event_count
   );
endinterface

// File: rtl/touch_event_gen.sv
// touch_event_gen: one debounced, clamped {x,y} word per physical press.
// Define TOUCH_AVG_EN to emit the mean of the debounce samples instead.
module touch_event_gen #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLDOFF_CYCLES  = 8,
   parameter int X_MAX           = 799,
   parameter int Y_MAX           = 479
) (
   input logic               clk,
   input logic               rst,
   touch_event_gen_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, HOLDOFF} state_t;

   localparam logic [7:0]  DBC = 8'(DEBOUNCE_CYCLES);
   localparam logic [7:0]  HOC = 8'(HOLDOFF_CYCLES);
   localparam logic [15:0] XM  = 16'(X_MAX);
   localparam logic [15:0] YM  = 16'(Y_MAX);

   state_t      r_state, w_next;
   logic [7:0]  r_cnt, w_cnt;
   logic [7:0]  r_hcnt, w_hcnt;
   logic [31:0] r_data;
   logic        r_event;
   logic        r_busy;
   logic [7:0]  r_count;
   logic        w_press, w_rel, w_fire;
   logic [15:0] w_x, w_y, w_cx, w_cy, w_oy;

   assign w_press = bus.raw_valid & bus.raw_pressed;
   assign w_rel   = bus.raw_valid & ~bus.raw_pressed;

`ifdef TOUCH_AVG_EN
   localparam int SH = $clog2(DEBOUNCE_CYCLES);
   localparam int AW = 16 + SH;

   if ((DEBOUNCE_CYCLES & (DEBOUNCE_CYCLES - 1)) != 0) begin : g_pow2
      $error("DEBOUNCE_CYCLES must be a power of two");
   end

   logic [AW-1:0] r_acc_x, r_acc_y, w_sum_x, w_sum_y;

   // first sample of a run restarts the running sum
   assign w_sum_x = ((r_state == IDLE) ? '0 : r_acc_x) + AW'(bus.raw_x);
   assign w_sum_y = ((r_state == IDLE) ? '0 : r_acc_y) + AW'(bus.raw_y);
   assign w_x     = 16'(w_sum_x >> SH);
   assign w_y     = 16'(w_sum_y >> SH);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc_x <= '0;
         r_acc_y <= '0;
      end else if (w_press &&
                   (r_state == IDLE || r_state == DEBOUNCE)) begin
         r_acc_x <= w_sum_x;
         r_acc_y <= w_sum_y;
      end
   end
`else
   assign w_x = bus.raw_x;
   assign w_y = bus.raw_y;
`endif

   assign w_cx = (w_x > XM) ? XM : w_x;
   assign w_cy = (w_y > YM) ? YM : w_y;
   assign w_oy = (w_cx == 16'd0 && w_cy == 16'd0) ? 16'd1 : w_cy;

   always_comb begin
      w_next = r_state;
      w_cnt  = r_cnt;
      w_hcnt = r_hcnt;
      w_fire = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_press) begin
               w_cnt = 8'd1;
               if (DBC == 8'd1) begin
                  w_next = HELD;
                  w_fire = 1'b1;
                  w_cnt  = '0;
               end else begin
                  w_next = DEBOUNCE;
               end
            end
         end
         DEBOUNCE: begin
            if (w_rel) begin
               w_next = IDLE;
               w_cnt  = '0;
            end else if (w_press) begin
               w_cnt = r_cnt + 8'd1;
               if (w_cnt == DBC) begin
                  w_next = HELD;
                  w_fire = 1'b1;
                  w_cnt  = '0;
               end
            end
         end
         HELD: begin
            if (w_rel) begin
               w_next = HOLDOFF;
               w_hcnt = '0;
            end
         end
         HOLDOFF: begin
            w_hcnt = r_hcnt + 8'd1;
            if (w_hcnt >= HOC) begin
               w_next = IDLE;
               w_hcnt = '0;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_hcnt  <= '0;
         r_data  <= '0;
         r_event <= 1'b0;
         r_busy  <= 1'b0;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
         r_hcnt  <= w_hcnt;
         r_event <= w_fire;
         r_data  <= w_fire ? {w_cx, w_oy} : 32'd0;
         r_busy  <= (w_next != IDLE);
         if (w_fire) r_count <= r_count + 8'd1;
      end
   end

   assign bus.touch_data  = r_data;
   assign bus.touch_event = r_event;
   assign bus.busy        = r_busy;
   assign bus.event_count = r_count;
endmodule

// File: tb/tb_touch_event_gen.sv
// tb_touch_event_gen: directed stimulus, cycle-by-cycle check against
// a press/holdoff model plus literal expectations per scenario.
module tb_touch_event_gen;
   localparam int N  = 4;
   localparam int H  = 8;
   localparam int XM = 799;
   localparam int YM = 479;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   touch_event_gen_if bus();

   touch_event_gen #(
      .DEBOUNCE_CYCLES(N),
      .HOLDOFF_CYCLES (H),
      .X_MAX          (XM),
      .Y_MAX          (YM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input int unsigned x,
                                        input int unsigned y);
      int unsigned cx, cy;
      logic [31:0] cxv, cyv;
      cx = (x > XM) ? XM : x;
      cy = (y > YM) ? YM : y;
      if (cx == 0 && cy == 0) cy = 1;
      cxv = cx;
      cyv = cy;
      return {cxv[15:0], cyv[15:0]};
   endfunction

   // model: count pressed samples in a run, ignore input until a cycle index
   int          cyc = 0;
   int          quiet_until = 0;
   int          run = 0;
   bit          held = 0;
   bit          started = 0;
   int unsigned sx = 0, sy = 0, lx = 0, ly = 0;
   logic [31:0] e_data = '0;
   logic        e_evt = 0;
   logic        e_busy = 0;
   logic [7:0]  e_cnt = '0;

   always @(posedge clk) begin
      cyc++;
      e_evt  = 1'b0;
      e_data = '0;
      if (rst) begin
         run = 0; held = 0; quiet_until = 0;
         sx = 0; sy = 0; e_cnt = '0;
      end else if (cyc < quiet_until) begin
      end else if (held) begin
         if (bus.raw_valid && !bus.raw_pressed) begin
            held = 0;
            quiet_until = cyc + ((H == 0) ? 1 : H) + 1;
         end
      end else if (bus.raw_valid) begin
         if (bus.raw_pressed) begin
            run++;
            sx += bus.raw_x; sy += bus.raw_y;
            lx = bus.raw_x;  ly = bus.raw_y;
            if (run == N) begin
`ifdef TOUCH_AVG_EN
               e_data = word(sx / N, sy / N);
`else
               e_data = word(lx, ly);
`endif
               e_evt = 1'b1;
               e_cnt = e_cnt + 8'd1;
               held = 1;
               run = 0; sx = 0; sy = 0;
            end
         end else begin
            run = 0; sx = 0; sy = 0;
         end
      end
      e_busy  = held || (run > 0) || (cyc + 1 < quiet_until);
      started = 1;
   end

   int          n_evt = 0;
   logic [31:0] last = '0;

   always @(posedge clk) begin
      #1;
      if (started) begin
         chk("data",  bus.touch_data, e_data);
         chk("event", 32'(bus.touch_event), 32'(e_evt));
         chk("busy",  32'(bus.busy), 32'(e_busy));
         chk("count", 32'(bus.event_count), 32'(e_cnt));
         if (bus.touch_event === 1'b1) begin
            n_evt++;
            last = bus.touch_data;
         end
      end
   end

   task automatic step(input logic v, input logic p,
                       input int unsigned x, input int unsigned y);
      bus.raw_valid   = v;
      bus.raw_pressed = p;
      bus.raw_x       = 16'(x);
      bus.raw_y       = 16'(y);
      @(posedge clk);
      #2;
   endtask

   task automatic press(input int unsigned x, input int unsigned y);
      step(1'b1, 1'b1, x, y);
   endtask

   task automatic rel();
      step(1'b1, 1'b0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
   endtask

   int base;

   initial begin
      bus.raw_valid = 0; bus.raw_pressed = 0;
      bus.raw_x = '0;    bus.raw_y = '0;
      rst = 1'b1;
      idle(2);
      chk("rst data",  bus.touch_data, 32'd0);
      chk("rst busy",  32'(bus.busy), 32'd0);
      chk("rst count", 32'(bus.event_count), 32'd0);
      rst = 1'b0;

      base = n_evt;
      repeat (3) press(20, 100);
      chk("t1 pre", 32'(bus.touch_event), 32'd0);
      press(20, 100);
      chk("t1 evt",  32'(bus.touch_event), 32'd1);
      chk("t1 data", bus.touch_data, 32'h0014_0064);
      press(20, 100);
      chk("t1 oneshot", 32'(bus.touch_event), 32'd0);
      repeat (9) press(20, 100);
      chk("t1 nevt",  32'(n_evt - base), 32'd1);
      chk("t1 count", 32'(bus.event_count), 32'd1);
      rel(); idle(9);

      base = n_evt;
      press(315, 100); press(315, 100); rel();
      chk("t2 nevt", 32'(n_evt - base), 32'd0);
      chk("t2 busy", 32'(bus.busy), 32'd0);
      chk("t2 count", 32'(bus.event_count), 32'd1);

      repeat (4) press(900, 500);
      chk("t3 clamp", last, 32'h031F_01DF);
      rel(); idle(9);
      repeat (4) press(0, 0);
      chk("t3 zero", last, 32'h0000_0001);
      rel(); idle(9);
      chk("t3 count", 32'(bus.event_count), 32'd3);

      base = n_evt;
      repeat (4) press(50, 60);
      rel();
      repeat (11) press(70, 80);
      chk("t4 holdoff", 32'(n_evt - base), 32'd1);
      press(70, 80);
      chk("t4 evt2",  32'(bus.touch_event), 32'd1);
      chk("t4 data2", bus.touch_data, 32'h0046_0050);
      chk("t4 count", 32'(bus.event_count), 32'd5);
      rel(); idle(9);

      base = n_evt;
      repeat (3) press(5, 5);
      rst = 1'b1;
      idle(1);
      chk("t5 rst busy",  32'(bus.busy), 32'd0);
      chk("t5 rst count", 32'(bus.event_count), 32'd0);
      rst = 1'b0;
      press(5, 5);
      chk("t5 no evt", 32'(n_evt - base), 32'd0);
      repeat (3) press(5, 5);
      chk("t5 evt", 32'(n_evt - base), 32'd1);
      chk("t5 count", 32'(bus.event_count), 32'd1);
      rel(); idle(9);

      press(10, 100); idle(1);
      press(20, 100); idle(2);
      press(30, 100); idle(1);
      press(40, 100);
`ifdef TOUCH_AVG_EN
      chk("t6 gaps", bus.touch_data, 32'h0019_0064);
`else
      chk("t6 gaps", bus.touch_data, 32'h0028_0064);
`endif
      rel(); idle(9);

      base = n_evt;
      for (int i = 0; i < 256; i++) begin
         repeat (4) press(i * 3, i * 2);
         rel(); idle(9);
         if (i == 253) chk("t7 wrap", 32'(bus.event_count), 32'd0);
      end
      chk("t7 nevt",  32'(n_evt - base), 32'd256);
      chk("t7 count", 32'(bus.event_count), 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
